// File: rtl/aes_ark_pkg.sv
// Shared AES AddRoundKey definitions: word size, round counts,
// round-index width helper and the output-buffer occupancy states.
package aes_ark_pkg;

    localparam int AES_WORD_W = 32;
    localparam int AES_NR_128 = 10;
    localparam int AES_NR_192 = 12;
    localparam int AES_NR_256 = 14;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    // Width of a round index able to address num_keys slots (at least 1 bit).
    function automatic int round_idx_w(input int num_keys);
        return (num_keys > 1) ? $clog2(num_keys) : 1;
    endfunction

endpackage

// File: rtl/add_round_key_pipe_if.sv
// Streaming state-in / result-out handshake bundle for add_round_key_pipe.
// The producer/consumer side uses master, the key-add stage uses slave.
interface add_round_key_pipe_if #(
    parameter int DATA_W   = 128,
    parameter int NUM_KEYS = 11
);
    localparam int ROUND_W = aes_ark_pkg::round_idx_w(NUM_KEYS);

    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic               in_auto;
    logic [ROUND_W-1:0] in_round;

    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [ROUND_W-1:0] out_round;
    logic               out_err;

    modport master (
        output in_valid, in_data, in_auto, in_round, out_ready,
        input  in_ready, out_valid, out_data, out_round, out_err
    );

    modport slave (
        input  in_valid, in_data, in_auto, in_round, out_ready,
        output in_ready, out_valid, out_data, out_round, out_err
    );

endinterface

// File: rtl/ark_skid_buf.sv
// Two-entry registered valid/ready FIFO. head_q always drives the output,
// so the popped word is stable until accepted and push_ready_o is registered-only.
module ark_skid_buf
    import aes_ark_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             pop_valid_o,
    input  logic             pop_ready_i,
    output logic [WIDTH-1:0] pop_data_o
);

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             push;
    logic             pop;

    assign push_ready_o = (state_q != BUF_FULL);
    assign pop_valid_o  = (state_q != BUF_EMPTY);
    assign pop_data_o   = head_q;
    assign push         = push_valid_i && push_ready_o;
    assign pop          = pop_ready_i && pop_valid_o;

    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush_i) begin
            state_d = BUF_EMPTY;
        end else begin
            unique case (state_q)
                BUF_EMPTY: begin
                    if (push) begin
                        head_d  = push_data_i;
                        state_d = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (push && pop) begin
                        head_d = push_data_i;
                    end else if (push) begin
                        tail_d  = push_data_i;
                        state_d = BUF_FULL;
                    end else if (pop) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    // No push is possible here: push_ready_o is low.
                    if (pop) begin
                        head_d  = tail_q;
                        state_d = BUF_ONE;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/add_round_key_pipe.sv
// Registered AES AddRoundKey stage: key bank, auto/explicit round select, XOR,
// 2-entry output buffer. Define ARK_ZEROIZE_EN to add the zeroize input.
module add_round_key_pipe #(
    parameter  int DATA_W   = 128,
    parameter  int NUM_KEYS = 11,
    localparam int ROUND_W  = aes_ark_pkg::round_idx_w(NUM_KEYS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_we,
    input  logic [ROUND_W-1:0] key_addr,
    input  logic [DATA_W-1:0]  key_data,
`ifdef ARK_ZEROIZE_EN
    input  logic               zeroize,
`endif
    add_round_key_pipe_if.slave bus
);

    localparam int                 ENTRY_W    = 1 + ROUND_W + DATA_W;
    localparam logic [ROUND_W:0]   NUM_KEYS_X = (ROUND_W + 1)'(NUM_KEYS);
    localparam logic [ROUND_W-1:0] LAST_IDX   = ROUND_W'(NUM_KEYS - 1);

    logic [DATA_W-1:0]  key_q [NUM_KEYS];
    logic [ROUND_W-1:0] round_ptr_q, round_ptr_d;
    logic               zeroize_w;
    logic               buf_ready;
    logic               accept;
    logic [ROUND_W-1:0] idx;
    logic               idx_err;
    logic [DATA_W-1:0]  key_sel;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] pop_entry;

`ifdef ARK_ZEROIZE_EN
    assign zeroize_w = zeroize;
`else
    assign zeroize_w = 1'b0;
`endif

    assign bus.in_ready = buf_ready && !zeroize_w;
    assign accept       = bus.in_valid && bus.in_ready;
    assign idx          = bus.in_auto ? round_ptr_q : bus.in_round;
    assign idx_err      = ({1'b0, idx} >= NUM_KEYS_X);

    // Out-of-range indices match no slot and therefore select an all-zero key.
    always_comb begin
        key_sel = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (idx == ROUND_W'(i)) key_sel = key_q[i];
        end
    end

    assign push_entry = {idx_err, idx, bus.in_data ^ key_sel};

    always_comb begin
        round_ptr_d = round_ptr_q;
        if (zeroize_w) begin
            round_ptr_d = '0;
        end else if (accept) begin
            round_ptr_d = (idx >= LAST_IDX) ? '0 : idx + ROUND_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            round_ptr_q <= '0;
        end else begin
            round_ptr_q <= round_ptr_d;
        end
    end

    // NOTE: the key bank is held in flops with a reset because key material
    // must read as zero after reset; it cannot be mapped onto reset-less RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_KEYS; i++) key_q[i] <= '0;
        end else if (zeroize_w) begin
            for (int i = 0; i < NUM_KEYS; i++) key_q[i] <= '0;
        end else if (key_we) begin
            // Addresses past the last slot match nothing and are dropped.
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (key_addr == ROUND_W'(i)) key_q[i] <= key_data;
            end
        end
    end

    ark_skid_buf #(
        .WIDTH (ENTRY_W)
    ) u_buf (
        .clk          (clk),
        .rst_n        (reset),
        .flush_i      (zeroize_w),
        .push_valid_i (accept),
        .push_ready_o (buf_ready),
        .push_data_i  (push_entry),
        .pop_valid_o  (bus.out_valid),
        .pop_ready_i  (bus.out_ready),
        .pop_data_o   (pop_entry)
    );

    assign bus.out_err   = pop_entry[ENTRY_W-1];
    assign bus.out_round = pop_entry[DATA_W +: ROUND_W];
    assign bus.out_data  = pop_entry[DATA_W-1:0];

endmodule
